vga_sync_decoder: RTL and testbench

- Receive side of the VGA output: samples HSync, VSync and rgb as produced by the display generator (MainModule), recovers pixel coordinates, checks timing against the configured mode, and declares lock.
- Used as an on-chip loopback checker and as a scoreboard front-end for display benches.
- Single clock; sampling is qualified by a pixel-rate enable.

---
 rtl/vga_timing_pkg.sv | 16 +
 rtl/vga_edge_counter.sv | 36 +++
 rtl/vga_sync_decoder.sv | 117 +++++++++++
 tb/tb_vga_sync_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and decoder FSM states.
// The display generator uses the same constants so both ends agree on the mode.
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;
  localparam int H_START  = H_SYNC + H_BP;
  localparam int V_START  = V_SYNC + V_BP;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
endpackage

// File: rtl/vga_edge_counter.sv
// Sync edge detector plus saturating counter that clears on the sync falling edge.
// Horizontal use counts every tick; vertical use counts HSync falls.
module vga_edge_counter #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          sync,
  input  logic          inc,
  output logic          fall,
  output logic          rise,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next
);
  logic q;

  assign fall = q & ~sync;
  assign rise = ~q & sync;

  always_comb begin
    cnt_next = cnt;
    if (fall) cnt_next = '0;
    else if (inc && cnt != '1) cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= 1'b1;
      cnt <= '0;
    end else if (pix_en) begin
      q   <= sync;
      cnt <= cnt_next;
    end
  end
endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive side: recovers pixel coordinates from HSync/VSync, checks timing
// against the configured mode and declares lock after clean frames.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          HSync,
  input  logic          VSync,
  input  logic [2:0]    rgb,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [2:0]    pix_rgb,
  output logic          pix_valid,
  output logic          frame_start,
  output logic          locked,
  output logic          timing_err
);
  localparam logic [CW-1:0] HEND  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] HSEND = CW'(H_SYNC - 1);
  localparam logic [CW-1:0] VEND  = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   VSW   = (CW+1)'(V_SYNC);
  localparam logic [CW-1:0] HST   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] HSP   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] VST   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] VSP   = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0]    LF    = 8'(LOCK_FRAMES);

  logic          hs_fall, hs_rise, vs_fall, vs_rise;
  logic [CW-1:0] hcnt, hcnt_nx, vcnt, vcnt_nx;
  logic          viol, lock_nx, pix_ok;
  logic [7:0]    good;
  state_t        state;

  vga_edge_counter #(.CW(CW)) u_h (
    .clk(clk), .rst(rst), .pix_en(pix_en), .sync(HSync), .inc(1'b1),
    .fall(hs_fall), .rise(hs_rise), .cnt(hcnt), .cnt_next(hcnt_nx)
  );

  vga_edge_counter #(.CW(CW)) u_v (
    .clk(clk), .rst(rst), .pix_en(pix_en), .sync(VSync), .inc(hs_fall),
    .fall(vs_fall), .rise(vs_rise), .cnt(vcnt), .cnt_next(vcnt_nx)
  );

  assign viol = (hs_fall && hcnt != HEND) ||
                (hs_rise && hcnt != HSEND) ||
                (vs_fall && vcnt != VEND) ||
                (vs_rise && hs_fall && ({1'b0, vcnt} + 1'b1) != VSW);

  // Lock as it will be after this tick; pixels are gated by it so a violation
  // drops pix_valid in the same tick that locked falls.
  always_comb begin
    lock_nx = 1'b0;
    if (state == LOCKED) lock_nx = !viol;
    else if (state == MEASURE) lock_nx = !viol && vs_fall && (good + 1'b1 == LF);
  end

  assign pix_ok = lock_nx && hcnt_nx >= HST && hcnt_nx < HSP &&
                  vcnt_nx >= VST && vcnt_nx < VSP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEARCH;
      good        <= '0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      locked      <= lock_nx;
      timing_err  <= viol && state != SEARCH;
      frame_start <= vs_fall;
      case (state)
        SEARCH: begin
          good <= '0;
          if (vs_fall) state <= MEASURE;
        end
        MEASURE: begin
          if (viol) state <= SEARCH;
          else if (vs_fall) begin
            good <= good + 1'b1;
            if (lock_nx) state <= LOCKED;
          end
        end
        LOCKED:  if (viol) state <= SEARCH;
        default: state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      pix_rgb   <= '0;
    end else if (pix_en) begin
      pix_valid <= pix_ok;
      if (pix_ok) begin
        x       <= hcnt_nx - HST;
        y       <= vcnt_nx - VST;
        pix_rgb <= rgb;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder in a reduced 20x10 mode: generated sync streams with
// faults and pix_en patterns, checked every clk against a tick-level model.
module tb_vga_sync_decoder;
  localparam int HT = 20, HSW = 2, HBP = 2, HA = 12;
  localparam int VT = 10, VSW = 1, VBP = 1, VA = 6;
  localparam int LF = 2, CW = 10, SAT = 1023;
  localparam int XS = HSW + HBP, YS = VSW + VBP;

  logic clk = 0, rst = 1, pix_en = 0, HSync = 1, VSync = 1;
  logic [2:0] rgb = 0;
  logic [CW-1:0] x, y;
  logic [2:0] pix_rgb;
  logic pix_valid, frame_start, locked, timing_err;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HSW), .H_BP(HBP), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VSW), .V_BP(VBP), .V_TOTAL(VT),
    .LOCK_FRAMES(LF), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .HSync(HSync), .VSync(VSync), .rgb(rgb),
    .x(x), .y(y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
  );

  int total = 0, bad = 0;
  int en_mode = 0;
  bit rgbx = 0, chk_on = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sync timing rules applied once per pixel tick.
  bit m_hsq, m_vsq;
  int m_h, m_v, m_phase, m_good, m_ticks = 0;
  bit e_pv, e_fs, e_lk, e_te;
  int e_x, e_y, e_rgb;

  task automatic model_reset();
    m_hsq = 1; m_vsq = 1; m_h = 0; m_v = 0; m_phase = 0; m_good = 0;
    e_pv = 0; e_fs = 0; e_lk = 0; e_te = 0; e_x = 0; e_y = 0; e_rgb = 0;
  endtask

  task automatic step(input bit hs, input bit vs, input int c);
    bit hf, hr, vf, vr, viol;
    int hn, vn, ph0;
    hf = m_hsq && !hs; hr = !m_hsq && hs;
    vf = m_vsq && !vs; vr = !m_vsq && vs;
    viol = (hf && m_h != HT-1) || (hr && m_h != HSW-1) || (vf && m_v != VT-1) ||
           (vr && hf && m_v + 1 != VSW);
    hn = hf ? 0 : (m_h < SAT ? m_h + 1 : SAT);
    vn = vf ? 0 : (hf ? (m_v < SAT ? m_v + 1 : SAT) : m_v);
    ph0 = m_phase;
    if (m_phase == 0) begin
      if (vf) begin m_phase = 1; m_good = 0; end
    end else if (viol) m_phase = 0;
    else if (vf) begin
      m_good++;
      if (m_phase == 1 && m_good == LF) m_phase = 2;
    end
    e_te = viol && ph0 != 0;
    e_fs = vf;
    e_lk = (m_phase == 2);
    e_pv = e_lk && hn >= XS && hn < XS + HA && vn >= YS && vn < YS + VA;
    if (e_pv) begin e_x = hn - XS; e_y = vn - YS; e_rgb = c; end
    m_h = hn; m_v = vn; m_hsq = hs; m_vsq = vs;
    m_ticks++;
  endtask

  // Per-clk compare plus per-tick statistics used by the scenario checks.
  int seen = 0, vf_seen = 0, err_seen = 0, lk_seen = 0, lock_rise_vf = -100;
  int pv_acc = 0, fx = -1, fy = -1, lx = -1, ly = -1;
  bit prev_lk = 0;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("locked", locked, e_lk);
      chk("pix_valid", pix_valid, e_pv);
      chk("frame_start", frame_start, e_fs);
      chk("timing_err", timing_err, e_te);
      if (e_pv) begin
        chk("x", x, e_x);
        chk("y", y, e_y);
        chk("pix_rgb", pix_rgb, e_rgb);
      end
      if (m_ticks != seen) begin
        seen = m_ticks;
        if (frame_start) begin vf_seen++; pv_acc = 0; end
        if (timing_err) err_seen++;
        if (locked) lk_seen++;
        if (locked && !prev_lk) lock_rise_vf = vf_seen;
        prev_lk = locked;
        if (pix_valid) begin
          if (pv_acc == 0) begin fx = x; fy = y; end
          lx = x; ly = y; pv_acc++;
          if (rgbx) chk("rgb_is_x", pix_rgb, int'(x[2:0]));
        end
      end
    end
  end

  // One pixel tick, preceded by idle clks carrying garbage that must be ignored.
  task automatic pix(input bit hs, input bit vs, input logic [2:0] c);
    int idle;
    idle = (en_mode == 1) ? 3 : (en_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < idle; i++) begin
      pix_en = 0; HSync = 1'($urandom); VSync = 1'($urandom); rgb = 3'($urandom);
      @(posedge clk); #2;
    end
    pix_en = 1; HSync = hs; VSync = vs; rgb = c;
    @(posedge clk);
    step(hs, vs, int'(c));
    #2;
  endtask

  task automatic mid_reset();
    chk("pre_reset_locked", locked, 1);
    #1 rst = 0;
    model_reset();
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_x", x, 0);
    chk("arst_y", y, 0);
    chk("arst_frame_start", frame_start, 0);
    chk("arst_timing_err", timing_err, 0);
    @(posedge clk); @(posedge clk);
    #3 rst = 1;
  endtask

  task automatic frame(input int fault_line, input int llen, input int hsw, input int vsw,
                       input int nlines, input int rst_at);
    int len;
    logic [2:0] c;
    for (int v = 0; v < nlines; v++) begin
      len = (v == fault_line) ? llen : HT;
      for (int h = 0; h < len; h++) begin
        c = rgbx ? 3'(h - XS) : 3'($urandom);
        if (v == rst_at && h == 7) mid_reset();
        pix(!(h < hsw), !(v < vsw), c);
      end
    end
  endtask

  task automatic clean();
    frame(-1, HT, HSW, VSW, VT, -1);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0; model_reset();
    @(posedge clk); #2 rst = 1;
  endtask

  int b_vf, b_err, b_lk, pick;

  initial begin
    model_reset();
    #1 rst = 0;
    #2;
    chk("rst_locked", locked, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_timing_err", timing_err, 0);
    chk_on = 1;
    @(posedge clk); #2 rst = 1;

    // Clean stream, pix_en every clk, rgb = x[2:0]
    b_vf = vf_seen; b_err = err_seen; rgbx = 1;
    repeat (3) clean();
    settle();
    chk("s1_lock_on_vf", lock_rise_vf - b_vf, 3);
    chk("s1_no_err", err_seen - b_err, 0);
    chk("s2_pix_count", pv_acc, 72);
    chk("s2_first_x", fx, 0);
    chk("s2_first_y", fy, 0);
    chk("s2_last_x", lx, 11);
    chk("s2_last_y", ly, 5);
    rgbx = 0;
    clean(); settle();
    chk("s2_pix_count_rand", pv_acc, 72);

    // One 19-tick line while locked
    b_err = err_seen;
    frame(5, 19, HSW, VSW, VT, -1); settle();
    chk("s3_one_err", err_seen - b_err, 1);
    chk("s3_unlocked", locked, 0);
    chk("s3_pix_stop", pv_acc, 48);
    b_vf = vf_seen;
    repeat (3) clean();
    settle();
    chk("s3_relock_vf", lock_rise_vf - b_vf, 3);

    // 1-of-4 pix_en with garbage on idle edges
    do_reset();
    en_mode = 1; b_vf = vf_seen; b_err = err_seen;
    repeat (3) clean();
    settle();
    chk("s4_lock_on_vf", lock_rise_vf - b_vf, 3);
    chk("s4_no_err", err_seen - b_err, 0);
    chk("s4_pix_count", pv_acc, 72);
    en_mode = 0;

    // Async reset mid-frame while locked
    frame(-1, HT, HSW, VSW, VT, 4); settle();
    b_vf = vf_seen;
    clean(); settle();
    chk("s5_frame_start", vf_seen - b_vf, 1);
    chk("s5_search", locked, 0);
    clean(); clean(); settle();
    chk("s5_relock_vf", lock_rise_vf - b_vf, 3);

    // HSync low for 3 ticks: never locks
    do_reset();
    b_err = err_seen; b_lk = lk_seen;
    repeat (3) frame(-1, HT, 3, VSW, VT, -1);
    settle();
    chk("s6_err_per_frame", err_seen - b_err, 3);
    chk("s6_never_locked", lk_seen - b_lk, 0);

    // Random pix_en and random faults, model-checked every clk
    do_reset();
    en_mode = 2;
    repeat (3) clean();
    for (int i = 0; i < 8; i++) begin
      pick = int'($urandom_range(0, 5));
      case (pick)
        1: frame(int'($urandom_range(0, VT-1)), 19, HSW, VSW, VT, -1);
        2: frame(int'($urandom_range(0, VT-1)), 21, HSW, VSW, VT, -1);
        3: frame(-1, HT, HSW, VSW, VT - 1, -1);
        4: frame(-1, HT, HSW, 2, VT, -1);
        5: frame(-1, HT, 3, VSW, VT, -1);
        default: clean();
      endcase
    end
    repeat (3) clean();
    settle();
    chk("rand_final_lock", locked, 1);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
